// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller.
// Holds the sequencer state encoding and the default datapath widths.
package dds_pkg;

    // Default widths: frequency word, phase word, dwell counter.
    localparam int DDS_KW = 32;
    localparam int DDS_PW = 11;
    localparam int DDS_DW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter that times how long each frequency word is held.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (counter -> 0)
//   load        load load_val this cycle (has priority over dec)
//   load_val    value to load
//   dec         decrement by one; saturates at zero
//   value       current count
//   zero        count is zero
module dds_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the K (frequency) and P (phase)
// words of a DDS phase accumulator. Sweeps K from a start word to a stop
// word in fixed steps, each word held cfg_dwell+1 cycles, once or repeating.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      one-cycle control pulses
//   cfg_*             sweep configuration, captured when a sweep starts
//   K, P              frequency / phase words to the DDS
//   busy              high while sweeping
//   done, wrap        one-cycle pulses: single sweep finished / repeat restart
//   state_dbg         sequencer state, for observation
//   dwell_dbg         current dwell count, for observation
//
// Control handshake: start and abort are single-cycle request pulses with no
// ready/acknowledge. Each is sampled on every rising edge. start is acted on
// only in IDLE (ignored in RUN); abort is acted on in any state and wins over
// a simultaneous start, step, wrap or done.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int KW = DDS_KW,
    parameter int PW = DDS_PW,
    parameter int DW = DDS_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] cfg_k_start,
    input  logic [KW-1:0] cfg_k_stop,
    input  logic [KW-1:0] cfg_k_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [PW-1:0] cfg_phase,
    input  logic          cfg_repeat,
    output logic [KW-1:0] K,
    output logic [PW-1:0] P,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output state_e        state_dbg,
    output logic [DW-1:0] dwell_dbg
);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [PW-1:0] p_q, p_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;

    // Shadow copy of the configuration, so cfg_* may change during a sweep.
    logic [KW-1:0] sh_start_q, sh_start_d;
    logic [KW-1:0] sh_stop_q, sh_stop_d;
    logic [KW-1:0] sh_step_q, sh_step_d;
    logic [DW-1:0] sh_dwell_q, sh_dwell_d;
    logic          sh_repeat_q, sh_repeat_d;

    logic          cnt_load;
    logic [DW-1:0] cnt_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [DW-1:0] cnt_value;

    // One extra bit catches the carry so a sweep near the top of the word
    // range terminates instead of wrapping around to a small frequency.
    logic [KW:0]   nxt;
    logic          can_step;

    assign nxt      = {1'b0, k_q} + {1'b0, sh_step_q};
    // A zero step can never advance, so it ends the sweep like passing stop.
    assign can_step = (sh_step_q != '0) && !nxt[KW] && (nxt[KW-1:0] <= sh_stop_q);

    dds_dwell_cnt #(.W(DW)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        p_d         = p_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        sh_start_d  = sh_start_q;
        sh_stop_d   = sh_stop_q;
        sh_step_d   = sh_step_q;
        sh_dwell_d  = sh_dwell_q;
        sh_repeat_d = sh_repeat_q;
        cnt_load    = 1'b0;
        cnt_val     = sh_dwell_q;
        cnt_dec     = 1'b0;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_start_d  = cfg_k_start;
                        sh_stop_d   = cfg_k_stop;
                        sh_step_d   = cfg_k_step;
                        sh_dwell_d  = cfg_dwell;
                        sh_repeat_d = cfg_repeat;
                        k_d         = cfg_k_start;
                        p_d         = cfg_phase;
                        cnt_load    = 1'b1;
                        cnt_val     = cfg_dwell;
                        busy_d      = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (can_step) begin
                        k_d      = nxt[KW-1:0];
                        cnt_load = 1'b1;
                    end else if (sh_repeat_q) begin
                        k_d      = sh_start_q;
                        cnt_load = 1'b1;
                        wrap_d   = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            p_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            sh_start_q  <= '0;
            sh_stop_q   <= '0;
            sh_step_q   <= '0;
            sh_dwell_q  <= '0;
            sh_repeat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            sh_start_q  <= sh_start_d;
            sh_stop_q   <= sh_stop_d;
            sh_step_q   <= sh_step_d;
            sh_dwell_q  <= sh_dwell_d;
            sh_repeat_q <= sh_repeat_d;
        end
    end

    assign K         = k_q;
    assign P         = p_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;
    assign dwell_dbg = cnt_value;

endmodule
